// File: rtl/beehive_noc_pkg.sv
// ---------------------------------------------------------------------------
// beehive_noc_pkg
// Shared types and constants for the Beehive dynamic-network output
// scheduler slice.
//   sched_state_e     : wormhole scheduler state (IDLE, HEAD, BODY)
//   ROUTE_A..ROUTE_X  : route-select codes for the five requesting inputs
//   *_DEF             : default sizes used by the scheduler and its bench
//   rr_index()        : wrapped index helper for the round-robin search
// ---------------------------------------------------------------------------
package beehive_noc_pkg;

   localparam int NOC_DATA_W_DEF      = 512;
   localparam int MSG_PAYLOAD_LEN_DEF = 22;
   localparam int NUM_IN_DEF          = 5;
   localparam int CREDITS_DEF         = 4;
   localparam int SEL_W_DEF           = $clog2(NUM_IN_DEF);

   // Route-select codes, in the order the datapath mux expects them
   localparam logic [SEL_W_DEF-1:0] ROUTE_A = 3'd0;
   localparam logic [SEL_W_DEF-1:0] ROUTE_B = 3'd1;
   localparam logic [SEL_W_DEF-1:0] ROUTE_C = 3'd2;
   localparam logic [SEL_W_DEF-1:0] ROUTE_D = 3'd3;
   localparam logic [SEL_W_DEF-1:0] ROUTE_X = 3'd4;

   // IDLE arbitrates, HEAD waits to send the header, BODY streams body flits
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      BODY = 2'd2
   } sched_state_e;

   // Index 'off' positions after 'last', wrapping at 'n'
   function automatic int rr_index(input int last, input int off, input int n);
      return (last + off) % n;
   endfunction

endpackage

// File: rtl/beehive_rr_pick.sv
// ---------------------------------------------------------------------------
// beehive_rr_pick
// Combinational round-robin picker. Searches the request vector starting one
// position past the previous grant and wrapping, so the most recently served
// input has the lowest priority.
// Ports:
//   req        in  NUM_IN  qualified requests (route request and valid)
//   last_grant in  SEL_W   input that completed the most recent packet
//   winner     out SEL_W   first requesting input after last_grant
//   any        out 1       at least one request present
// ---------------------------------------------------------------------------
module beehive_rr_pick
   import beehive_noc_pkg::*;
#(
   parameter int NUM_IN = NUM_IN_DEF,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  last_grant,
   output logic [SEL_W-1:0]  winner,
   output logic              any
);

   logic             found;
   logic [SEL_W-1:0] idx;

   // Walk offsets 1..NUM_IN from last_grant; the first hit wins. Offset
   // NUM_IN lands back on last_grant itself, so a lone requester that was
   // also the previous winner is still served.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int off = 1; off <= NUM_IN; off++) begin
         idx = SEL_W'(rr_index(int'(last_grant), off, NUM_IN));
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/beehive_dynamic_output_sched.sv
// ---------------------------------------------------------------------------
// beehive_dynamic_output_sched
// Wormhole scheduler for one dynamic-network output port. Grants one input
// queue at a time by round-robin, keeps that grant for the whole packet
// (header plus the number of body flits given by the header length field),
// and only forwards a flit while a downstream credit is available.
// Ports:
//   clk          in  1                clock
//   reset        in  1                asynchronous active-high reset
//   route_req_in in  NUM_IN           input i has a head flit routed here
//   valid_in     in  NUM_IN           input i has a flit at its head
//   sel_len_in   in  MSG_PAYLOAD_LEN  length field of the flit selected by sel_out
//   yummy_in     in  1                one credit returned by downstream
//   sel_out      out SEL_W            registered route select to the datapath mux
//   valid_out    out 1                flit on the datapath output is valid
//   thanks_out   out NUM_IN           one-hot pop of the granted input
//   busy_out     out 1                a packet grant is active
//   stall_out    out 1                granted input has a flit but no credit
// ---------------------------------------------------------------------------
module beehive_dynamic_output_sched
   import beehive_noc_pkg::*;
#(
   parameter int MSG_PAYLOAD_LEN = MSG_PAYLOAD_LEN_DEF,
   parameter int NUM_IN          = NUM_IN_DEF,
   parameter int CREDITS         = CREDITS_DEF,
   parameter int SEL_W           = $clog2(NUM_IN)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_IN-1:0]          route_req_in,
   input  logic [NUM_IN-1:0]          valid_in,
   input  logic [MSG_PAYLOAD_LEN-1:0] sel_len_in,
   input  logic                       yummy_in,
   output logic [SEL_W-1:0]           sel_out,
   output logic                       valid_out,
   output logic [NUM_IN-1:0]          thanks_out,
   output logic                       busy_out,
   output logic                       stall_out
);

   localparam int CRED_W = $clog2(CREDITS + 1);
   localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDITS);
   localparam logic [MSG_PAYLOAD_LEN-1:0] LEN_ONE = MSG_PAYLOAD_LEN'(1);

   sched_state_e               state_q, state_d;
   logic [SEL_W-1:0]           sel_q, sel_d;
   logic [SEL_W-1:0]           last_grant_q, last_grant_d;
   logic [MSG_PAYLOAD_LEN-1:0] remaining_q, remaining_d;
   logic [CRED_W-1:0]          credits_q, credits_d;

   logic [NUM_IN-1:0] req;
   logic [SEL_W-1:0]  pick_winner;
   logic              pick_any;
   logic              granted;
   logic              head_valid;
   logic              have_credit;
   logic              send;

   // Only inputs that both route here and actually hold a flit may compete
   assign req = route_req_in & valid_in;

   beehive_rr_pick #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_pick (
      .req        (req),
      .last_grant (last_grant_q),
      .winner     (pick_winner),
      .any        (pick_any)
   );

   // A flit moves when a grant is held, the granted queue has a flit and
   // downstream has room. The grant cycle itself is IDLE, which is what
   // produces the one-cycle bubble ahead of every header.
   assign granted     = (state_q != IDLE);
   assign head_valid  = valid_in[sel_q];
   assign have_credit = (credits_q != '0);
   assign send        = granted & head_valid & have_credit;

   assign sel_out    = sel_q;
   assign valid_out  = send;
   assign thanks_out = send ? (NUM_IN'(1) << sel_q) : '0;
   assign busy_out   = granted;
   assign stall_out  = granted & head_valid & ~have_credit;

   // Next-state logic for the packet FSM, the length counter and the credit
   // counter. The select only moves in IDLE, so the datapath mux is stable
   // for the whole packet even if the granted input drops its request.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      remaining_d  = remaining_q;
      credits_d    = credits_q;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               sel_d   = pick_winner;
               state_d = HEAD;
            end
         end
         HEAD: begin
            if (send) begin
               remaining_d = sel_len_in;
               if (sel_len_in == '0) begin
                  state_d      = IDLE;
                  last_grant_d = sel_q;
               end else begin
                  state_d = BODY;
               end
            end
         end
         BODY: begin
            // The <= guard keeps the counter from wrapping if BODY were
            // ever entered with nothing left to send.
            if (send) begin
               if (remaining_q <= LEN_ONE) begin
                  remaining_d  = '0;
                  state_d      = IDLE;
                  last_grant_d = sel_q;
               end else begin
                  remaining_d = remaining_q - LEN_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A returned credit and a consumed credit in the same cycle cancel.
      // An extra yummy at full credit is a protocol error and is ignored.
      if (send && !yummy_in) begin
         credits_d = credits_q - CRED_W'(1);
      end else if (yummy_in && !send && (credits_q != CRED_FULL)) begin
         credits_d = credits_q + CRED_W'(1);
      end
   end

   // State registers. Reset drops any grant in flight and assumes the
   // downstream buffer was reset alongside, hence full credits. last_grant
   // starts at the top input so the first search begins at input 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         last_grant_q <= SEL_W'(NUM_IN - 1);
         remaining_q  <= '0;
         credits_q    <= CRED_FULL;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         remaining_q  <= remaining_d;
         credits_q    <= credits_d;
      end
   end

   // Downstream must never return more credits than its buffer holds
   credit_overflow_a : assert property (
      @(posedge clk) disable iff (reset)
      !(yummy_in && !send && (credits_q == CRED_FULL))
   );

endmodule

// File: tb/tb_beehive_dynamic_output_sched.sv
// ---------------------------------------------------------------------------
// tb_beehive_dynamic_output_sched
// Directed bench for the output scheduler. Each task runs one scenario and
// compares the packed output word {sel_out, valid_out, thanks_out, busy_out,
// stall_out} (11 bits) against hand-derived values, plus a few internal
// counters where the scenario is about them.
// ---------------------------------------------------------------------------
module tb_beehive_dynamic_output_sched;
   import beehive_noc_pkg::*;

   logic        clk;
   logic        reset;
   logic [4:0]  route_req_in;
   logic [4:0]  valid_in;
   logic [21:0] sel_len_in;
   logic        yummy_in;
   logic [2:0]  sel_out;
   logic        valid_out;
   logic [4:0]  thanks_out;
   logic        busy_out;
   logic        stall_out;

   logic [10:0] obs;
   int          checks;
   int          failures;

   assign obs = {sel_out, valid_out, thanks_out, busy_out, stall_out};

   beehive_dynamic_output_sched dut (
      .clk          (clk),
      .reset        (reset),
      .route_req_in (route_req_in),
      .valid_in     (valid_in),
      .sel_len_in   (sel_len_in),
      .yummy_in     (yummy_in),
      .sel_out      (sel_out),
      .valid_out    (valid_out),
      .thanks_out   (thanks_out),
      .busy_out     (busy_out),
      .stall_out    (stall_out)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something never returns
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold reset across two edges, release just after an edge
   task automatic do_reset();
      reset        = 1'b1;
      route_req_in = '0;
      valid_in     = '0;
      sel_len_in   = '0;
      yummy_in     = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Outputs and counters while reset is held, even with requests present
   task automatic test_reset();
      reset        = 1'b1;
      route_req_in = 5'b11111;
      valid_in     = 5'b11111;
      sel_len_in   = 22'd3;
      yummy_in     = 1'b0;
      @(posedge clk);
      #2;
      checks++;
      if (obs !== 11'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs got=%b exp=%b", obs, 11'b0);
      end
      checks++;
      if (dut.credits_q !== 3'd4) begin
         failures++;
         $display("[TB] FAIL reset_credits got=%0d exp=4", dut.credits_q);
      end
      checks++;
      if (dut.remaining_q !== 22'd0) begin
         failures++;
         $display("[TB] FAIL reset_remaining got=%0d exp=0", dut.remaining_q);
      end
      @(posedge clk);
      #1;
      route_req_in = '0;
      valid_in     = '0;
      reset        = 1'b0;
   endtask

   // Single header-only packet from input C
   task automatic test_single_len0();
      do_reset();
      route_req_in = 5'b00100;
      valid_in     = 5'b00100;
      sel_len_in   = 22'd0;
      #1;
      checks++;
      if (obs !== 11'b000_0_00000_0_0) begin
         failures++;
         $display("[TB] FAIL single_bubble got=%b exp=%b", obs, 11'b000_0_00000_0_0);
      end
      step();
      checks++;
      if (obs !== {ROUTE_C, 1'b1, 5'b00100, 1'b1, 1'b0}) begin
         failures++;
         $display("[TB] FAIL single_head got=%b exp=%b", obs, {ROUTE_C, 1'b1, 5'b00100, 1'b1, 1'b0});
      end
      step();
      route_req_in = '0;
      valid_in     = '0;
      #1;
      checks++;
      if (obs !== {ROUTE_C, 1'b0, 5'b00000, 1'b0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL single_done got=%b exp=%b", obs, {ROUTE_C, 1'b0, 5'b00000, 1'b0, 1'b0});
      end
      checks++;
      if (dut.credits_q !== 3'd3) begin
         failures++;
         $display("[TB] FAIL single_credits got=%0d exp=3", dut.credits_q);
      end
   endtask

   // Inputs A, B, X all request two-flit packets; grants rotate with wrap
   task automatic test_rr_order();
      logic [2:0]  order [4];
      logic [2:0]  prev;
      logic [10:0] exp_v;
      order = '{ROUTE_A, ROUTE_B, ROUTE_X, ROUTE_A};
      do_reset();
      route_req_in = 5'b10011;
      valid_in     = 5'b10011;
      sel_len_in   = 22'd1;
      prev         = 3'd0;
      for (int p = 0; p < 4; p++) begin
         yummy_in = (p != 0);
         #1;
         exp_v = {prev, 1'b0, 5'b00000, 1'b0, 1'b0};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("[TB] FAIL rr_bubble pkt=%0d got=%b exp=%b", p, obs, exp_v);
         end
         step();
         yummy_in = 1'b0;
         #1;
         exp_v = {order[p], 1'b1, 5'b00001 << order[p], 1'b1, 1'b0};
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("[TB] FAIL rr_head pkt=%0d got=%b exp=%b", p, obs, exp_v);
         end
         step();
         yummy_in = 1'b1;
         #1;
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("[TB] FAIL rr_body pkt=%0d got=%b exp=%b", p, obs, exp_v);
         end
         step();
         prev = order[p];
      end
      route_req_in = '0;
      valid_in     = '0;
      yummy_in     = 1'b1;
      step();
      yummy_in = 1'b0;
      #1;
      checks++;
      if (dut.credits_q !== 3'd4) begin
         failures++;
         $display("[TB] FAIL rr_credits got=%0d exp=4", dut.credits_q);
      end
   endtask

   // Input D, length 5, credits run out mid-body; single yummy pulses
   task automatic test_credit_stall();
      logic [10:0] exp_t [10];
      logic        yum_t [10];
      int          sent;
      exp_t = '{11'b000_0_00000_0_0,
                {ROUTE_D, 1'b1, 5'b01000, 1'b1, 1'b0},
                {ROUTE_D, 1'b1, 5'b01000, 1'b1, 1'b0},
                {ROUTE_D, 1'b1, 5'b01000, 1'b1, 1'b0},
                {ROUTE_D, 1'b1, 5'b01000, 1'b1, 1'b0},
                {ROUTE_D, 1'b0, 5'b00000, 1'b1, 1'b1},
                {ROUTE_D, 1'b1, 5'b01000, 1'b1, 1'b0},
                {ROUTE_D, 1'b0, 5'b00000, 1'b1, 1'b1},
                {ROUTE_D, 1'b1, 5'b01000, 1'b1, 1'b0},
                {ROUTE_D, 1'b0, 5'b00000, 1'b0, 1'b0}};
      yum_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      sent  = 0;
      do_reset();
      route_req_in = 5'b01000;
      valid_in     = 5'b01000;
      sel_len_in   = 22'd5;
      for (int c = 0; c < 10; c++) begin
         yummy_in = yum_t[c];
         #1;
         checks++;
         if (obs !== exp_t[c]) begin
            failures++;
            $display("[TB] FAIL stall_cycle c=%0d got=%b exp=%b", c, obs, exp_t[c]);
         end
         if (c == 5) begin
            checks++;
            if (dut.remaining_q !== 22'd2) begin
               failures++;
               $display("[TB] FAIL stall_remaining got=%0d exp=2", dut.remaining_q);
            end
         end
         if (valid_out === 1'b1) sent++;
         step();
      end
      route_req_in = '0;
      valid_in     = '0;
      yummy_in     = 1'b0;
      checks++;
      if (sent !== 6) begin
         failures++;
         $display("[TB] FAIL stall_flits got=%0d exp=6", sent);
      end
   endtask

   // Send and yummy together with one credit left leave the count at one
   task automatic test_send_and_yummy();
      logic [10:0] exp_t [7];
      logic        yum_t [7];
      exp_t = '{11'b000_0_00000_0_0,
                {ROUTE_B, 1'b1, 5'b00010, 1'b1, 1'b0},
                {ROUTE_B, 1'b1, 5'b00010, 1'b1, 1'b0},
                {ROUTE_B, 1'b1, 5'b00010, 1'b1, 1'b0},
                {ROUTE_B, 1'b1, 5'b00010, 1'b1, 1'b0},
                {ROUTE_B, 1'b1, 5'b00010, 1'b1, 1'b0},
                {ROUTE_B, 1'b0, 5'b00000, 1'b1, 1'b1}};
      yum_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      do_reset();
      route_req_in = 5'b00010;
      valid_in     = 5'b00010;
      sel_len_in   = 22'd7;
      for (int c = 0; c < 7; c++) begin
         yummy_in = yum_t[c];
         #1;
         checks++;
         if (obs !== exp_t[c]) begin
            failures++;
            $display("[TB] FAIL both_cycle c=%0d got=%b exp=%b", c, obs, exp_t[c]);
         end
         if (c == 4 || c == 5) begin
            checks++;
            if (dut.credits_q !== 3'd1) begin
               failures++;
               $display("[TB] FAIL both_credits c=%0d got=%0d exp=1", c, dut.credits_q);
            end
         end
         step();
      end
      yummy_in = 1'b0;
   endtask

   // Granted input A goes empty mid-body while C keeps requesting
   task automatic test_valid_gap();
      logic [10:0] exp_t [10];
      int          sent;
      exp_t = '{11'b000_0_00000_0_0,
                {ROUTE_A, 1'b1, 5'b00001, 1'b1, 1'b0},
                {ROUTE_A, 1'b1, 5'b00001, 1'b1, 1'b0},
                {ROUTE_A, 1'b0, 5'b00000, 1'b1, 1'b0},
                {ROUTE_A, 1'b0, 5'b00000, 1'b1, 1'b0},
                {ROUTE_A, 1'b0, 5'b00000, 1'b1, 1'b0},
                {ROUTE_A, 1'b1, 5'b00001, 1'b1, 1'b0},
                {ROUTE_A, 1'b1, 5'b00001, 1'b1, 1'b0},
                {ROUTE_A, 1'b0, 5'b00000, 1'b0, 1'b0},
                {ROUTE_C, 1'b0, 5'b00000, 1'b1, 1'b1}};
      sent = 0;
      do_reset();
      route_req_in = 5'b00101;
      sel_len_in   = 22'd3;
      for (int c = 0; c < 10; c++) begin
         valid_in = (c >= 3 && c <= 5) ? 5'b00100 : 5'b00101;
         #1;
         checks++;
         if (obs !== exp_t[c]) begin
            failures++;
            $display("[TB] FAIL gap_cycle c=%0d got=%b exp=%b", c, obs, exp_t[c]);
         end
         if (valid_out === 1'b1) sent++;
         step();
      end
      route_req_in = '0;
      valid_in     = '0;
      checks++;
      if (sent !== 4) begin
         failures++;
         $display("[TB] FAIL gap_flits got=%0d exp=4", sent);
      end
   endtask

   // Reset lands mid-body; afterwards arbitration restarts from input A
   task automatic test_reset_mid_packet();
      do_reset();
      route_req_in = 5'b01000;
      valid_in     = 5'b01000;
      sel_len_in   = 22'd0;
      step();
      step();
      sel_len_in = 22'd9;
      step();
      step();
      step();
      step();
      #1;
      checks++;
      if (obs !== {ROUTE_D, 1'b0, 5'b00000, 1'b1, 1'b1}) begin
         failures++;
         $display("[TB] FAIL mid_pre got=%b exp=%b", obs, {ROUTE_D, 1'b0, 5'b00000, 1'b1, 1'b1});
      end
      checks++;
      if (dut.remaining_q !== 22'd7) begin
         failures++;
         $display("[TB] FAIL mid_remaining got=%0d exp=7", dut.remaining_q);
      end
      #1;
      reset        = 1'b1;
      route_req_in = 5'b10010;
      valid_in     = 5'b10010;
      #1;
      checks++;
      if (obs !== 11'b0) begin
         failures++;
         $display("[TB] FAIL mid_reset_out got=%b exp=%b", obs, 11'b0);
      end
      checks++;
      if (dut.credits_q !== 3'd4) begin
         failures++;
         $display("[TB] FAIL mid_reset_credits got=%0d exp=4", dut.credits_q);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++;
      if (obs !== 11'b0) begin
         failures++;
         $display("[TB] FAIL mid_idle got=%b exp=%b", obs, 11'b0);
      end
      step();
      checks++;
      if (obs !== {ROUTE_B, 1'b1, 5'b00010, 1'b1, 1'b0}) begin
         failures++;
         $display("[TB] FAIL mid_regrant got=%b exp=%b", obs, {ROUTE_B, 1'b1, 5'b00010, 1'b1, 1'b0});
      end
      route_req_in = '0;
      valid_in     = '0;
   endtask

   // Run every scenario in order, then report
   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      route_req_in = '0;
      valid_in     = '0;
      sel_len_in   = '0;
      yummy_in     = 1'b0;
      $display("[TB] start, flit width %0d", NOC_DATA_W_DEF);
      test_reset();
      test_single_len0();
      test_rr_order();
      test_credit_stall();
      test_send_and_yummy();
      test_valid_gap();
      test_reset_mid_packet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
